// File: rtl/axi4lite_wb_bridge.sv
// AXI4-Lite slave to Wishbone classic master bridge.
// Handles one transaction at a time and arbitrates fairly between reads and writes.
// A Wishbone access that never terminates is closed with SLVERR once the cycle budget runs out.
module axi4lite_wb_bridge #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    // AXI4-Lite write address channel
    output logic                            o_axi_awready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]     i_axi_awaddr,
    input  logic [2:0]                      i_axi_awprot,
    input  logic                            i_axi_awvalid,
    // AXI4-Lite write data channel
    output logic                            o_axi_wready,
    input  logic [C_AXI_DATA_WIDTH-1:0]     i_axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]   i_axi_wstrb,
    input  logic                            i_axi_wvalid,
    // AXI4-Lite write response channel
    output logic [1:0]                      o_axi_bresp,
    output logic                            o_axi_bvalid,
    input  logic                            i_axi_bready,
    // AXI4-Lite read address channel
    output logic                            o_axi_arready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]     i_axi_araddr,
    input  logic [2:0]                      i_axi_arprot,
    input  logic                            i_axi_arvalid,
    // AXI4-Lite read data channel
    output logic [C_AXI_DATA_WIDTH-1:0]     o_axi_rdata,
    output logic [1:0]                      o_axi_rresp,
    output logic                            o_axi_rvalid,
    input  logic                            i_axi_rready,
    // Wishbone classic master
    output logic                            o_wb_cyc,
    output logic                            o_wb_stb,
    output logic                            o_wb_we,
    output logic [C_AXI_ADDR_WIDTH-3:0]     o_wb_adr,
    output logic [C_AXI_DATA_WIDTH-1:0]     o_wb_dat,
    output logic [C_AXI_DATA_WIDTH/8-1:0]   o_wb_sel,
    input  logic                            i_wb_ack,
    input  logic                            i_wb_err,
    input  logic [C_AXI_DATA_WIDTH-1:0]     i_wb_dat
);

    localparam int DW = C_AXI_DATA_WIDTH;
    localparam int AW = C_AXI_ADDR_WIDTH;
    localparam int SW = C_AXI_DATA_WIDTH / 8;

    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;
    localparam logic          PRIO_WRITE  = 1'b0;
    localparam logic          PRIO_READ   = 1'b1;
    localparam logic [15:0]   CNT_LAST    = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0] DATA_ZERO   = {DW{1'b0}};
    localparam logic [SW-1:0] SEL_ALL     = {SW{1'b1}};
    localparam logic [SW-1:0] SEL_NONE    = {SW{1'b0}};
    localparam logic [AW-3:0] ADR_ZERO    = {(AW-2){1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WB_WR = 3'd1,
        ST_WB_RD = 3'd2,
        ST_BRESP = 3'd3,
        ST_RRESP = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;

    // Keeps the ready outputs low while reset is applied and for the first cycle after it
    logic            ready_en_r;
    logic            aw_have_r;
    logic            w_have_r;
    logic [AW-3:0]   aw_adr_r;
    logic [DW-1:0]   w_data_r;
    logic [SW-1:0]   w_strb_r;
    logic            prio_r;
    logic [15:0]     cnt_r;
    logic [AW-3:0]   wb_adr_r;
    logic [DW-1:0]   wb_dat_r;
    logic [SW-1:0]   wb_sel_r;
    logic [1:0]      resp_r;
    logic [DW-1:0]   rdata_r;

    logic            in_wb_s;
    logic            wr_rdy_s;
    logic            ar_grant_s;
    logic            wr_grant_s;
    logic            timeout_s;
    logic            wb_done_s;

    logic            awready_s;
    logic            wready_s;
    logic            arready_s;
    logic            bvalid_s;
    logic            rvalid_s;
    logic [1:0]      bresp_s;
    logic [1:0]      rresp_s;
    logic            wb_cyc_s;
    logic            wb_we_s;

    // Protection bits and the byte offset within a word have no Wishbone counterpart
    logic            unused_s;
    assign unused_s = ^{i_axi_awprot, i_axi_arprot, i_axi_awaddr[1:0], i_axi_araddr[1:0]};

    assign in_wb_s    = (state_r == ST_WB_WR) || (state_r == ST_WB_RD);
    assign wr_rdy_s   = aw_have_r && w_have_r;
    assign ar_grant_s = (state_r == ST_IDLE) && i_axi_arvalid && arready_s;
    assign wr_grant_s = (state_r == ST_IDLE) && wr_rdy_s && !ar_grant_s;
    assign timeout_s  = (cnt_r == CNT_LAST);
    assign wb_done_s  = i_wb_ack || i_wb_err || timeout_s;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: grant in IDLE, wait for termination, wait for the AXI response handshake
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ar_grant_s) begin
                    state_nxt_s = ST_WB_RD;
                end else if (wr_grant_s) begin
                    state_nxt_s = ST_WB_WR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WB_WR: begin
                if (wb_done_s) begin
                    state_nxt_s = ST_BRESP;
                end else begin
                    state_nxt_s = ST_WB_WR;
                end
            end
            ST_WB_RD: begin
                if (wb_done_s) begin
                    state_nxt_s = ST_RRESP;
                end else begin
                    state_nxt_s = ST_WB_RD;
                end
            end
            ST_BRESP: begin
                if (i_axi_bready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BRESP;
                end
            end
            ST_RRESP: begin
                if (i_axi_rready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RRESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state only, so no input-to-output combinational path exists
    always_comb begin
        awready_s = 1'b0;
        wready_s  = 1'b0;
        arready_s = 1'b0;
        bvalid_s  = 1'b0;
        rvalid_s  = 1'b0;
        bresp_s   = RESP_OKAY;
        rresp_s   = RESP_OKAY;
        wb_cyc_s  = 1'b0;
        wb_we_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                awready_s = ready_en_r && !aw_have_r;
                wready_s  = ready_en_r && !w_have_r;
                arready_s = ready_en_r && !(wr_rdy_s && (prio_r == PRIO_WRITE));
            end
            ST_WB_WR: begin
                wb_cyc_s = 1'b1;
                wb_we_s  = 1'b1;
            end
            ST_WB_RD: begin
                wb_cyc_s = 1'b1;
            end
            ST_BRESP: begin
                bvalid_s = 1'b1;
                bresp_s  = resp_r;
            end
            ST_RRESP: begin
                rvalid_s = 1'b1;
                rresp_s  = resp_r;
            end
            default: begin
                wb_cyc_s = 1'b0;
            end
        endcase
    end

    assign o_axi_awready = awready_s;
    assign o_axi_wready  = wready_s;
    assign o_axi_arready = arready_s;
    assign o_axi_bvalid  = bvalid_s;
    assign o_axi_bresp   = bresp_s;
    assign o_axi_rvalid  = rvalid_s;
    assign o_axi_rresp   = rresp_s;
    assign o_axi_rdata   = rdata_r;
    assign o_wb_cyc      = wb_cyc_s;
    assign o_wb_stb      = wb_cyc_s;
    assign o_wb_we       = wb_we_s;
    assign o_wb_adr      = wb_adr_r;
    assign o_wb_dat      = wb_dat_r;
    assign o_wb_sel      = wb_sel_r;

    // Enable the ready outputs one cycle after reset release
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // Collect write address and write data independently; both are consumed by a write grant
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_have_r <= 1'b0;
            w_have_r  <= 1'b0;
            aw_adr_r  <= ADR_ZERO;
            w_data_r  <= DATA_ZERO;
            w_strb_r  <= SEL_NONE;
        end else if (wr_grant_s) begin
            aw_have_r <= 1'b0;
            w_have_r  <= 1'b0;
        end else begin
            if (awready_s && i_axi_awvalid) begin
                aw_have_r <= 1'b1;
                aw_adr_r  <= i_axi_awaddr[AW-1:2];
            end
            if (wready_s && i_axi_wvalid) begin
                w_have_r <= 1'b1;
                w_data_r <= i_axi_wdata;
                w_strb_r <= i_axi_wstrb;
            end
        end
    end

    // Alternate priority: whichever side was just served yields the next tie
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_r <= PRIO_WRITE;
        end else if (ar_grant_s) begin
            prio_r <= PRIO_WRITE;
        end else if (wr_grant_s) begin
            prio_r <= PRIO_READ;
        end
    end

    // Load the Wishbone request at grant; it stays stable for the whole access
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_adr_r <= ADR_ZERO;
            wb_dat_r <= DATA_ZERO;
            wb_sel_r <= SEL_NONE;
        end else if (ar_grant_s) begin
            wb_adr_r <= i_axi_araddr[AW-1:2];
            wb_dat_r <= DATA_ZERO;
            wb_sel_r <= SEL_ALL;
        end else if (wr_grant_s) begin
            wb_adr_r <= aw_adr_r;
            wb_dat_r <= w_data_r;
            wb_sel_r <= w_strb_r;
        end
    end

    // Count cycles spent waiting on the Wishbone slave; cleared whenever no access is pending
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= 16'd0;
        end else if (in_wb_s && !wb_done_s) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= 16'd0;
        end
    end

    // Capture the termination: err beats ack, timeout reports SLVERR with zero data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_r  <= RESP_OKAY;
            rdata_r <= DATA_ZERO;
        end else if (in_wb_s && wb_done_s) begin
            if (i_wb_err) begin
                resp_r  <= RESP_SLVERR;
                rdata_r <= DATA_ZERO;
            end else if (i_wb_ack) begin
                resp_r  <= RESP_OKAY;
                rdata_r <= (state_r == ST_WB_RD) ? i_wb_dat : DATA_ZERO;
            end else begin
                resp_r  <= RESP_SLVERR;
                rdata_r <= DATA_ZERO;
            end
        end
    end

endmodule
